alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 34 +++
 rtl/alu_ctrl_decode.sv | 42 ++++
 rtl/alu_issue_stage.sv | 103 ++++++++++
 tb/tb_alu_issue_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage_pkg
// Description : Shared ALU encodings: main-control ALUOp classes, R-type
//               funct values and the 3-bit ALU-control operation codes.
//               Used by the issue-stage decoder and by the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_stage_pkg;

    // Main-control ALU class
    localparam logic [1:0] c_ALUOP_MEM    = 2'b00;  // load/store/addi -> add
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;  // beq -> subtract
    localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;  // operation from funct
    localparam logic [1:0] c_ALUOP_RSVD   = 2'b11;  // unsupported

    // R-type function field values
    localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
    localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
    localparam logic [5:0] c_FUNCT_AND = 6'b100100;
    localparam logic [5:0] c_FUNCT_OR  = 6'b100101;
    localparam logic [5:0] c_FUNCT_SLT = 6'b101010;

    // ALU control codes
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

endpackage : alu_issue_stage_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational ALU-control decoder. Maps ALUOp/funct to a
//               3-bit ALU operation and flags unsupported combinations.
// Ports       : alu_op  - main-control ALU class
//               funct   - R-type function field
//               code    - decoded ALU operation (ADD for illegal decodes)
//               illegal - decode is not a supported operation
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctrl_e  code,
    output logic       illegal
);

    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            c_ALUOP_MEM:    code = ALU_ADD;
            c_ALUOP_BRANCH: code = ALU_SUB;
            c_ALUOP_RTYPE: begin
                case (funct)
                    c_FUNCT_ADD: code = ALU_ADD;
                    c_FUNCT_SUB: code = ALU_SUB;
                    c_FUNCT_AND: code = ALU_AND;
                    c_FUNCT_OR:  code = ALU_OR;
                    c_FUNCT_SLT: code = ALU_SLT;
                    default:     illegal = 1'b1;  // code stays ADD
                endcase
            end
            default:        illegal = 1'b1;       // reserved class
        endcase
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ALU issue pipeline register. Decodes the ALU operation,
//               selects operand B, and registers operands/code with
//               stall (hold), flush (squash) and illegal-op dropping.
// Ports       : clock__i, reset__i (sync, active-high)
//               valid__i, ALUOp__i, funct__i, regA__i, regB__i, imm__i,
//               ALUSrc__i, stall__i, flush__i          - decode-side inputs
//               ready__o                               - !stall (comb)
//               dataA__o, dataB__o, ALUControl__o,
//               valid__o                               - registered issue
//               illegal__o, illegal_count__o           - dropped-op report
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clock__i,
    input  logic              reset__i,
    input  logic              valid__i,
    input  logic [1:0]        ALUOp__i,
    input  logic [5:0]        funct__i,
    input  logic [DATA_W-1:0] regA__i,
    input  logic [DATA_W-1:0] regB__i,
    input  logic [DATA_W-1:0] imm__i,
    input  logic              ALUSrc__i,
    input  logic              stall__i,
    input  logic              flush__i,
    output logic              ready__o,
    output logic [DATA_W-1:0] dataA__o,
    output logic [DATA_W-1:0] dataB__o,
    output logic [2:0]        ALUControl__o,
    output logic              valid__o,
    output logic              illegal__o,
    output logic [CNT_W-1:0]  illegal_count__o
);

    alu_ctrl_e         w_code;
    logic              w_illegal;
    logic [DATA_W-1:0] w_operand_b;
    logic              w_accept;
    logic              w_drop;

    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [2:0]        r_alu_ctrl;
    logic              r_valid;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_illegal_count;

    alu_ctrl_decode u_decode (
        .alu_op  (ALUOp__i),
        .funct   (funct__i),
        .code    (w_code),
        .illegal (w_illegal)
    );

    assign w_operand_b = ALUSrc__i ? imm__i : regB__i;
    // Stage loads only when neither squashed nor held.
    assign w_accept    = !flush__i && !stall__i;
    // A dropped op is only reported when it was really issued into the stage.
    assign w_drop      = w_accept && valid__i && w_illegal;

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            r_data_a        <= '0;
            r_data_b        <= '0;
            r_alu_ctrl      <= 3'b000;
            r_valid         <= 1'b0;
            r_illegal       <= 1'b0;
            r_illegal_count <= '0;
        end else begin
            r_illegal <= w_drop;
            if (w_drop && (r_illegal_count != {CNT_W{1'b1}})) begin
                r_illegal_count <= r_illegal_count + 1'b1;
            end

            if (flush__i) begin
                // Squash only the valid bit; operands keep their last value.
                r_valid <= 1'b0;
            end else if (!stall__i) begin
                r_data_a   <= regA__i;
                r_data_b   <= w_operand_b;
                r_alu_ctrl <= w_code;
                r_valid    <= valid__i && !w_illegal;
            end
        end
    end

    assign ready__o         = !stall__i;
    assign dataA__o         = r_data_a;
    assign dataB__o         = r_data_b;
    assign ALUControl__o    = r_alu_ctrl;
    assign valid__o         = r_valid;
    assign illegal__o       = r_illegal;
    assign illegal_count__o = r_illegal_count;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage. A cycle-level
//               reference model is compared against the DUT on every
//               falling edge; directed vectors add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid_in = 1'b0;
    logic [1:0]        alu_op = 2'b00;
    logic [5:0]        funct = 6'b0;
    logic [DATA_W-1:0] reg_a = '0;
    logic [DATA_W-1:0] reg_b = '0;
    logic [DATA_W-1:0] imm = '0;
    logic              alu_src = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;

    logic              ready;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [2:0]        alu_ctrl;
    logic              valid_out;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock__i         (clk),
        .reset__i         (rst),
        .valid__i         (valid_in),
        .ALUOp__i         (alu_op),
        .funct__i         (funct),
        .regA__i          (reg_a),
        .regB__i          (reg_b),
        .imm__i           (imm),
        .ALUSrc__i        (alu_src),
        .stall__i         (stall),
        .flush__i         (flush),
        .ready__o         (ready),
        .dataA__o         (data_a),
        .dataB__o         (data_b),
        .ALUControl__o    (alu_ctrl),
        .valid__o         (valid_out),
        .illegal__o       (illegal),
        .illegal_count__o (illegal_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode table: returns {illegal, code}
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return {1'b0, 3'b010};
        if (op == 2'b01) return {1'b0, 3'b110};
        if (op == 2'b10) begin
            if (f == 6'b100000) return {1'b0, 3'b010};
            if (f == 6'b100010) return {1'b0, 3'b110};
            if (f == 6'b100100) return {1'b0, 3'b000};
            if (f == 6'b100101) return {1'b0, 3'b001};
            if (f == 6'b101010) return {1'b0, 3'b111};
        end
        return {1'b1, 3'b010};
    endfunction

    // Reference model state
    bit          known = 0;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_code;
    bit          m_valid, m_ill;
    int          m_cnt;

    always @(posedge clk) begin
        logic [3:0] d;
        bit take;
        d = ref_decode(alu_op, funct);
        if (rst) begin
            known = 1; m_a = 0; m_b = 0; m_code = 0; m_valid = 0; m_ill = 0; m_cnt = 0;
        end else if (known) begin
            take  = !flush && !stall;
            m_ill = take && valid_in && d[3];
            if (m_ill && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_a     = reg_a;
                m_b     = alu_src ? imm : reg_b;
                m_code  = d[2:0];
                m_valid = valid_in && !d[3];
            end
        end
    end

    always @(negedge clk) begin
        if (known) begin
            check("mdl_ready",   {31'b0, ready},     {31'b0, !stall});
            check("mdl_valid",   {31'b0, valid_out}, {31'b0, m_valid});
            check("mdl_illegal", {31'b0, illegal},   {31'b0, m_ill});
            check("mdl_count",   {24'b0, illegal_count}, m_cnt);
            check("mdl_ctrl",    {29'b0, alu_ctrl},  {29'b0, m_code});
            check("mdl_dataA",   data_a, m_a);
            check("mdl_dataB",   data_b, m_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic src);
        valid_in = v; alu_op = op; funct = f; reg_a = a; reg_b = b; imm = im; alu_src = src;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(); step();
        check("rst_valid", {31'b0, valid_out}, 0);
        check("rst_count", {24'b0, illegal_count}, 0);
        check("rst_dataA", data_a, 0);
        check("rst_ctrl",  {29'b0, alu_ctrl}, 0);
        rst = 1'b0;

        // R-type SUB
        set_in(1, 2'b10, 6'b100010, 7, 3, 32'h99, 0);
        step();
        check("sub_ctrl",  {29'b0, alu_ctrl}, 3'b110);
        check("sub_dataA", data_a, 7);
        check("sub_dataB", data_b, 3);
        check("sub_valid", {31'b0, valid_out}, 1);

        // Memory op with immediate
        set_in(1, 2'b00, 6'b000000, 32'h100, 32'h5, 32'hFFFF_FFFC, 1);
        step();
        check("mem_ctrl",  {29'b0, alu_ctrl}, 3'b010);
        check("mem_dataA", data_a, 32'h100);
        check("mem_dataB", data_b, 32'hFFFF_FFFC);
        check("mem_valid", {31'b0, valid_out}, 1);

        // Remaining legal decodes, model-checked
        set_in(1, 2'b01, 6'b111111, 1, 2, 3, 0); step();
        check("br_ctrl", {29'b0, alu_ctrl}, 3'b110);
        set_in(1, 2'b10, 6'b100000, 4, 5, 6, 0); step();
        set_in(1, 2'b10, 6'b100100, 8, 9, 10, 0); step();
        set_in(1, 2'b10, 6'b101010, 11, 12, 13, 1); step();
        check("slt_ctrl",  {29'b0, alu_ctrl}, 3'b111);
        check("slt_dataB", data_b, 13);
        set_in(0, 2'b10, 6'b100101, 14, 15, 16, 0); step();
        check("novalid", {31'b0, valid_out}, 0);

        // Stall for three cycles with changing inputs
        set_in(1, 2'b10, 6'b100101, 32'h11, 32'h22, 0, 0); step();
        check("pre_stall_ctrl", {29'b0, alu_ctrl}, 3'b001);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2'b01, 6'b0, 32'h40 + i, 32'h50 + i, 32'h60 + i, 1);
            #1;
            check("stall_ready", {31'b0, ready}, 0);
            step();
            check("stall_dataA", data_a, 32'h11);
            check("stall_ctrl",  {29'b0, alu_ctrl}, 3'b001);
            check("stall_valid", {31'b0, valid_out}, 1);
        end
        stall = 1'b0;
        set_in(1, 2'b10, 6'b100100, 32'h33, 32'h44, 0, 0);
        step();
        check("unstall_dataA", data_a, 32'h33);
        check("unstall_dataB", data_b, 32'h44);
        check("unstall_ctrl",  {29'b0, alu_ctrl}, 3'b000);

        // Stall and flush together: flush wins
        stall = 1'b1; flush = 1'b1;
        set_in(1, 2'b00, 6'b0, 32'h55, 32'h66, 0, 0);
        step();
        check("flush_valid", {31'b0, valid_out}, 0);
        check("flush_dataA", data_a, 32'h33);
        stall = 1'b0;
        step();   // flush alone with a valid instruction
        check("flush2_valid", {31'b0, valid_out}, 0);
        flush = 1'b0;

        // Illegal R-type funct
        set_in(1, 2'b10, 6'b000000, 1, 1, 1, 0);
        step();
        check("ill_valid", {31'b0, valid_out}, 0);
        check("ill_pulse", {31'b0, illegal}, 1);
        check("ill_count", {24'b0, illegal_count}, 1);
        set_in(0, 2'b00, 6'b0, 2, 2, 2, 0);
        step();
        check("ill_pulse_end", {31'b0, illegal}, 0);
        // Illegal while stalled / not valid: no event
        stall = 1'b1;
        set_in(1, 2'b11, 6'b0, 3, 3, 3, 0);
        step();
        check("ill_stall_pulse", {31'b0, illegal}, 0);
        check("ill_stall_count", {24'b0, illegal_count}, 1);
        stall = 1'b0;
        set_in(0, 2'b11, 6'b0, 3, 3, 3, 0);
        step();
        check("ill_novalid_count", {24'b0, illegal_count}, 1);
        // Reserved ALUOp
        set_in(1, 2'b11, 6'b100000, 3, 3, 3, 0);
        step();
        check("rsvd_pulse", {31'b0, illegal}, 1);
        check("rsvd_count", {24'b0, illegal_count}, 2);
        // Saturation
        set_in(1, 2'b10, 6'b000000, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step();
        check("sat_count", {24'b0, illegal_count}, 255);
        set_in(0, 2'b00, 6'b0, 0, 0, 0, 0);
        step();

        // Reset during a stall holding a valid instruction
        set_in(1, 2'b00, 6'b0, 9, 8, 7, 0);
        step();
        check("pre_rst_valid", {31'b0, valid_out}, 1);
        stall = 1'b1; rst = 1'b1;
        step();
        check("midrst_valid", {31'b0, valid_out}, 0);
        check("midrst_dataA", data_a, 0);
        check("midrst_dataB", data_b, 0);
        check("midrst_ctrl",  {29'b0, alu_ctrl}, 0);
        check("midrst_count", {24'b0, illegal_count}, 0);
        rst = 1'b0; stall = 1'b0;
        set_in(1, 2'b10, 6'b100010, 5, 2, 0, 0);
        step();
        check("postrst_dataA", data_a, 5);
        check("postrst_ctrl",  {29'b0, alu_ctrl}, 3'b110);
        check("postrst_valid", {31'b0, valid_out}, 1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
